// File: rtl/ps2_rx_fifo.sv
// PS/2 frame receiver with a first-word fall-through byte FIFO; valid rises 1 cycle after the stop-bit fall is detected.
// Consumer backpressure: bytes wait in the FIFO while ready=0; a good byte arriving when full is dropped and flagged.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ps2_clk,
  input  logic                        ps2_data,
  output logic [7:0]                  data_out,
  output logic                        valid,
  input  logic                        ready,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow,
  output logic                        parity_err,
  output logic                        frame_err,
  input  logic                        clr_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, RECV} state_t;

  logic          clk_s1, clk_s2, clk_prev;
  logic          dat_s1, dat_s2;
  logic          fall;
  state_t        state;
  logic [3:0]    bit_cnt;
  logic [8:0]    shreg;
  logic [TW-1:0] to_cnt;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          full, pop, push, good, drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1   <= 1'b1;
      clk_s2   <= 1'b1;
      clk_prev <= 1'b1;
      dat_s1   <= 1'b1;
      dat_s2   <= 1'b1;
    end else begin
      clk_s1   <= ps2_clk;
      clk_s2   <= clk_s1;
      clk_prev <= clk_s2;
      dat_s1   <= ps2_data;
      dat_s2   <= dat_s1;
    end
  end

  assign fall = clk_prev & ~clk_s2;

  // shreg holds {parity, d7..d0} once the stop bit arrives
  assign good  = (state == RECV) && fall && (bit_cnt == 4'd10) && dat_s2 && (^shreg);
  assign valid = (fifo_count != '0);
  assign full  = (fifo_count == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH));
  assign pop   = valid && ready;
  assign push  = good && (!full || pop);
  assign drop  = good && full && !pop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= 4'd0;
      shreg      <= 9'd0;
      to_cnt     <= '0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          to_cnt <= '0;
          if (fall && !dat_s2) begin
            state   <= RECV;
            bit_cnt <= 4'd1;
          end
        end
        RECV: begin
          if (fall) begin
            to_cnt <= '0;
            if (bit_cnt == 4'd10) begin
              state   <= IDLE;
              bit_cnt <= 4'd0;
              if (!dat_s2)
                frame_err <= 1'b1;
              else if (!(^shreg))
                parity_err <= 1'b1;
            end else begin
              shreg   <= {dat_s2, shreg[8:1]};
              bit_cnt <= bit_cnt + 4'd1;
            end
          end else if (to_cnt == TO_LAST) begin
            frame_err <= 1'b1;
            state     <= IDLE;
            bit_cnt   <= 4'd0;
            to_cnt    <= '0;
          end else begin
            to_cnt <= to_cnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
      if (drop)
        overflow <= 1'b1;
      else if (clr_err)
        overflow <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= shreg[7:0];
  end

  assign data_out = valid ? mem[rptr] : 8'h00;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Bench for ps2_rx_fifo: directed frames from the test plan plus randomized frames against a queue model.
module tb_ps2_rx_fifo;
  localparam int DEPTH = 8;
  localparam int TO    = 300;
  localparam int HALF  = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ready = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] data_out;
  logic       valid, overflow, parity_err, frame_err;
  logic [3:0] fifo_count;

  int total = 0;
  int bad = 0;
  int perr_cyc = 0;
  int ferr_cyc = 0;
  logic [7:0] q[$];
  bit ovf_m = 0;

  ps2_rx_fifo #(.FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .data_out(data_out), .valid(valid), .ready(ready), .fifo_count(fifo_count),
    .overflow(overflow), .parity_err(parity_err), .frame_err(frame_err), .clr_err(clr_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (parity_err === 1'b1) perr_cyc++;
    if (frame_err === 1'b1) ferr_cyc++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".count"}, 32'(fifo_count), q.size());
    chk({tag, ".valid"}, 32'(valid), (q.size() != 0) ? 1 : 0);
    chk({tag, ".data"}, 32'(data_out), (q.size() != 0) ? 32'(q[0]) : 0);
    chk({tag, ".ovf"}, 32'(overflow), 32'(ovf_m));
  endtask

  task automatic pop_one(input string tag);
    @(negedge clk);
    chk({tag, ".head"}, 32'(data_out), (q.size() != 0) ? 32'(q[0]) : 0);
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    if (q.size() != 0) void'(q.pop_front());
  endtask

  // mode 0: plain; mode 1: pop during the stop-bit evaluation cycle; mode 2: measure cycles to valid
  task automatic send_frame(input logic [7:0] d, input bit bad_par, input logic stop,
                            input int mode, output int lat);
    logic [10:0] bits;
    bits = {stop, (~^d) ^ bad_par, d, 1'b0};
    lat = -1;
    for (int i = 0; i < 11; i++) begin
      ps2_data = bits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i == 10 && mode == 1) begin
        @(posedge clk);
        @(posedge clk);
        #1 ready = 1'b1;
        @(posedge clk);
        #1 ready = 1'b0;
        repeat (HALF - 2) @(negedge clk);
      end else if (i == 10 && mode == 2) begin
        for (int n = 1; n <= HALF; n++) begin
          @(posedge clk);
          #1;
          if (valid === 1'b1 && lat < 0) lat = n;
        end
        @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
  endtask

  task automatic do_frame(input logic [7:0] d, input bit bad_par, input logic stop, input string tag);
    int p0, f0, lat;
    p0 = perr_cyc;
    f0 = ferr_cyc;
    send_frame(d, bad_par, stop, 0, lat);
    if (stop && !bad_par) begin
      if (q.size() < DEPTH) q.push_back(d);
      else ovf_m = 1;
    end
    chk({tag, ".perr"}, perr_cyc - p0, (stop && bad_par) ? 1 : 0);
    chk({tag, ".ferr"}, ferr_cyc - f0, stop ? 0 : 1);
    check_state(tag);
  endtask

  task automatic clear_ovf();
    @(negedge clk);
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    ovf_m = 0;
  endtask

  initial begin
    int lat, f0;
    logic [10:0] pbits;

    repeat (3) @(negedge clk);
    chk("rst.valid", 32'(valid), 0);
    chk("rst.count", 32'(fifo_count), 0);
    chk("rst.data", 32'(data_out), 0);
    chk("rst.ovf", 32'(overflow), 0);
    chk("rst.errs", 32'({parity_err, frame_err}), 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    send_frame(8'h1C, 0, 1'b1, 2, lat);
    q.push_back(8'h1C);
    chk("lat.valid", lat, 3);
    check_state("first");
    pop_one("first");
    check_state("first.popped");

    do_frame(8'h1C, 1, 1'b1, "par_bad");
    do_frame(8'hF0, 0, 1'b1, "f0");
    pop_one("f0");

    do_frame(8'h55, 0, 1'b0, "stop_bad");
    do_frame(8'h55, 1, 1'b0, "stop_par_bad");

    for (int i = 1; i <= 9; i++) do_frame(8'(i), 0, 1'b1, $sformatf("fill%0d", i));
    for (int i = 0; i < DEPTH; i++) pop_one($sformatf("drain%0d", i));
    check_state("drained");
    clear_ovf();
    check_state("clr");

    for (int i = 0; i < DEPTH; i++) do_frame(8'h30 + 8'(i), 0, 1'b1, $sformatf("full%0d", i));
    send_frame(8'hAA, 0, 1'b1, 1, lat);
    void'(q.pop_front());
    q.push_back(8'hAA);
    check_state("coincide");
    while (q.size() != 0) pop_one("coincide.drain");

    // timeout: start plus three data bits, then the bus goes quiet
    pbits = {1'b1, ~^8'h05, 8'h05, 1'b0};
    f0 = ferr_cyc;
    lat = -1;
    for (int i = 0; i < 4; i++) begin
      ps2_data = pbits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      if (i < 3) begin
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
      end else begin
        for (int n = 1; n <= TO + 20; n++) begin
          @(posedge clk);
          #1;
          if (n == HALF) ps2_clk = 1'b1;
          if (frame_err === 1'b1 && lat < 0) lat = n;
        end
      end
    end
    ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    chk("timeout.lat", lat, TO + 3);
    chk("timeout.ferr", ferr_cyc - f0, 1);
    check_state("timeout");
    do_frame(8'h5A, 0, 1'b1, "after_to");
    pop_one("after_to");

    do_frame(8'h77, 0, 1'b1, "pre_rst");
    pbits = {1'b1, ~^8'h3C, 8'h3C, 1'b0};
    for (int i = 0; i < 5; i++) begin
      ps2_data = pbits[i];
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      ps2_clk = 1'b1;
    end
    rst_n = 1'b0;
    ps2_data = 1'b1;
    q.delete();
    ovf_m = 0;
    repeat (3) @(negedge clk);
    check_state("midrst");
    chk("midrst.errs", 32'({parity_err, frame_err}), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    do_frame(8'hC3, 0, 1'b1, "post_rst");
    pop_one("post_rst");

    for (int k = 0; k < 40; k++) begin
      int kind, npop;
      logic [7:0] d;
      kind = $urandom_range(0, 5);
      d = 8'($urandom);
      if (kind == 0) do_frame(d, 1, 1'b1, "rnd.par");
      else if (kind == 1) do_frame(d, bit'($urandom_range(0, 1)), 1'b0, "rnd.stop");
      else do_frame(d, 0, 1'b1, "rnd.good");
      npop = $urandom_range(0, 2);
      for (int j = 0; j < npop; j++) if (q.size() != 0) pop_one("rnd.pop");
      if (ovf_m && $urandom_range(0, 3) == 0) begin
        clear_ovf();
        check_state("rnd.clr");
      end
    end
    while (q.size() != 0) pop_one("final.drain");
    check_state("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ps2_rx_fifo.md
Name: ps2_rx_fifo

Overview:
Serial front-end upstream of the 8-bit shift/parallel-load register. It receives PS/2 device frames on the ps2_clk/ps2_data pins and checks start, parity and stop bits. Good bytes are buffered in a small FIFO and presented with valid/ready, so the downstream stage can parallel-load them (shiftIn) at its own pace.

Parameters:
FIFO_DEPTH, 8, number of buffered bytes; power of 2, minimum 2
TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge mid-frame before the frame is aborted

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
ps2_clk  input  1  PS/2 clock pin; asynchronous to clk
ps2_data  input  1  PS/2 data pin; asynchronous to clk
data_out  output  8  FIFO head byte; 8'h00 whenever valid=0
valid  output  1  FIFO non-empty
ready  input  1  consumer accepts the head byte when valid&&ready
fifo_count  output  $clog2(FIFO_DEPTH)+1  bytes currently buffered
overflow  output  1  sticky: a good byte was dropped because the FIFO was full
parity_err  output  1  one-cycle pulse: frame discarded for bad parity
frame_err  output  1  one-cycle pulse: frame discarded for bad stop bit or timeout
clr_err  input  1  synchronous clear of overflow

Behaviour:
- Reset (rst_n=0, asynchronous): FIFO empty; valid=0, data_out=0, fifo_count=0, overflow=0, parity_err=0, frame_err=0; receiver in IDLE; bit counter and timeout counter 0; synchronizers preset to 1 (bus idle). A reset mid-frame discards the partial frame.
- Synchronization: ps2_clk and ps2_data each pass through 2 flops. A third flop on ps2_clk gives the previous value. fall = prev & ~sync. Data is sampled from synced ps2_data in the cycle where fall=1. Pin-to-fall latency is 2-3 clk cycles.
- Frame format: start(0), d0..d7 (LSB first), odd parity, stop(1). Eleven falling edges make one frame.
- FSM:
  - IDLE: on fall with data=0, go to RECV with bit_cnt=1. On fall with data=1, stay in IDLE (spurious edge, no error).
  - RECV: on each fall, shift the data bit in and increment bit_cnt. When bit_cnt reaches 10 and this fall samples the stop bit, evaluate the frame and return to IDLE.
  - Timeout in RECV: the counter resets on each fall and otherwise increments. At TIMEOUT_CYCLES-1 the frame is aborted: pulse frame_err, go to IDLE, push nothing.
- Frame evaluation, in the cycle the stop bit is sampled:
  - stop=0: frame_err pulse.
  - else parity wrong (^{d7..d0,p} != 1): parity_err pulse.
  - else good byte. Push it if the FIFO is not full, or if it is full and a pop occurs in the same cycle. Otherwise drop the byte and set overflow.
  - The stop-bit check takes priority when both stop and parity are wrong: only frame_err pulses.
- Error pulses are registered, high for exactly the cycle after evaluation.
- FIFO:
  - First-word fall-through; circular read/write pointers with wrap at FIFO_DEPTH.
  - A push at clock edge N makes valid=1 and data_out=byte in the cycle after edge N (empty case). Total latency from stop-bit fall to valid is 1 cycle.
  - Pop when valid&&ready. Simultaneous push and pop keeps fifo_count unchanged.
  - ready with valid=0 has no effect.
- overflow clears on clr_err=1. If a drop and clr_err occur in the same cycle, the set wins.
- Arithmetic: fifo_count never exceeds FIFO_DEPTH. Pointers are $clog2(FIFO_DEPTH) bits, and full/empty are derived from fifo_count.

Test Plan:
- Send frame for 8'h1C (parity bit 0, stop 1) with ready=0 -> valid rises 1 cycle after stop-bit fall; data_out=8'h1C; fifo_count=1. Raise ready for one cycle -> valid=0, data_out=8'h00.
- Send 8'h1C with parity bit 1 -> parity_err pulses once; valid stays 0; then 8'hF0 with parity 1 -> data_out=8'hF0.
- Send 8'h55 with correct parity and stop bit 0 -> frame_err pulses once; no push. Send 8'h55 with stop bit 0 and wrong parity -> frame_err only.
- With ready=0, send 9 good bytes 8'h01..8'h09 -> fifo_count=8 and overflow=1 after the 9th. Then pop all: order 01..08, 09 absent. Pulse clr_err -> overflow=0.
- With FIFO full, send a 10th byte (8'hAA) whose stop-bit evaluation coincides with ready=1 -> byte accepted, fifo_count stays 8, overflow unchanged.
- Send start plus 3 data bits then idle -> frame_err pulse TIMEOUT_CYCLES after the last fall. The next complete frame 8'h5A is received correctly. Assert rst_n low mid-frame -> all outputs 0 and the subsequent frame decodes cleanly.
